// File: rtl/gps_sample_packer_if.sv
// Byte stream handshake from the GPS sample packer to the SPI bridge.
//   BYTE_DATA  : head-of-FIFO byte (8'h00 when nothing is queued)
//   BYTE_VALID : FIFO holds at least one byte
//   BYTE_READY : consumer accepts the head byte this cycle
// master = packer (producer), slave = SPI state machine (consumer).
interface gps_sample_packer_if;
    logic [7:0] BYTE_DATA;
    logic       BYTE_VALID;
    logic       BYTE_READY;

    modport master (
        output BYTE_DATA,
        output BYTE_VALID,
        input  BYTE_READY
    );

    modport slave (
        input  BYTE_DATA,
        input  BYTE_VALID,
        output BYTE_READY
    );
endinterface

// File: rtl/gps_sample_packer.sv
// Packs 4-bit GPS I/Q samples ({I1,I0,Q1,Q0}) two per byte, first sample in
// the high nibble, and buffers the bytes in a first-word-fall-through FIFO.
// When the FIFO is full, bytes are dropped; this sets a sticky OVERFLOW flag
// and bumps a saturating DROP_COUNT.
// Ports:
//   MCU_CLK_25_000 : sole clock
//   RESET_P        : synchronous active-high reset
//   DATAREADY      : one-cycle strobe per GPS sample
//   GPS_I0/I1/Q0/Q1: sample bits, valid with DATAREADY
//   byte_if        : BYTE_DATA / BYTE_VALID / BYTE_READY handshake (master)
//   FIFO_LEVEL     : number of stored bytes, 0..FIFO_DEPTH
//   OVERFLOW       : sticky, set on the first dropped byte
//   DROP_COUNT     : dropped bytes, saturating at 255
module gps_sample_packer #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned ADDR_W     = 4
) (
    input  logic                 MCU_CLK_25_000,
    input  logic                 RESET_P,
    input  logic                 DATAREADY,
    input  logic                 GPS_I0,
    input  logic                 GPS_I1,
    input  logic                 GPS_Q0,
    input  logic                 GPS_Q1,
    gps_sample_packer_if.master  byte_if,
    output logic [ADDR_W:0]      FIFO_LEVEL,
    output logic                 OVERFLOW,
    output logic [7:0]           DROP_COUNT
);
    localparam int unsigned LVL_W = ADDR_W + 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    typedef enum logic {
        HALF_EMPTY = 1'b0,
        HALF_FULL  = 1'b1
    } pack_state_t;

    pack_state_t       state;
    pack_state_t       state_n;
    logic [3:0]        hold_nibble;
    logic [3:0]        sample_nibble;
    logic [7:0]        push_byte;
    logic              hold_load;
    logic              push;

    logic [7:0]        mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] rd_ptr_n;
    logic              full;
    logic              push_ok;
    logic              drop;
    logic              pop;
    logic [LVL_W-1:0]  level_n;
    logic [7:0]        head_n;

    assign sample_nibble = {GPS_I1, GPS_I0, GPS_Q1, GPS_Q0};
    assign push_byte     = {hold_nibble, sample_nibble};

    // Pack FSM: next state and strobe decode
    always_comb begin
        state_n   = state;
        hold_load = 1'b0;
        push      = 1'b0;
        case (state)
            HALF_EMPTY: begin
                if (DATAREADY) begin
                    hold_load = 1'b1;
                    state_n   = HALF_FULL;
                end
            end
            HALF_FULL: begin
                if (DATAREADY) begin
                    push    = 1'b1;
                    state_n = HALF_EMPTY;
                end
            end
        endcase
    end

    // Full test uses the pre-cycle level, so a same-cycle pop cannot rescue a push
    assign full     = (FIFO_LEVEL == LVL_FULL);
    assign push_ok  = push & ~full;
    assign drop     = push & full;
    assign pop      = byte_if.BYTE_VALID & byte_if.BYTE_READY;
    assign rd_ptr_n = rd_ptr + ADDR_W'(pop);

    // Level after this edge
    always_comb begin
        level_n = FIFO_LEVEL;
        case ({push_ok, pop})
            2'b10:   level_n = FIFO_LEVEL + LVL_W'(1);
            2'b01:   level_n = FIFO_LEVEL - LVL_W'(1);
            default: level_n = FIFO_LEVEL;
        endcase
    end

    // Head after this edge; the incoming byte bypasses memory when it lands at the head
    always_comb begin
        head_n = 8'h00;
        if (level_n != '0) begin
            if (push_ok && (FIFO_LEVEL == LVL_W'(pop))) begin
                head_n = push_byte;
            end else begin
                head_n = mem[rd_ptr_n];
            end
        end
    end

    // Control state, pointers, registered outputs
    always_ff @(posedge MCU_CLK_25_000) begin
        if (RESET_P) begin
            state              <= HALF_EMPTY;
            hold_nibble        <= '0;
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            FIFO_LEVEL         <= '0;
            byte_if.BYTE_VALID <= 1'b0;
            byte_if.BYTE_DATA  <= 8'h00;
            OVERFLOW           <= 1'b0;
            DROP_COUNT         <= 8'h00;
        end else begin
            state <= state_n;
            if (hold_load) begin
                hold_nibble <= sample_nibble;
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            rd_ptr             <= rd_ptr_n;
            FIFO_LEVEL         <= level_n;
            byte_if.BYTE_VALID <= (level_n != '0);
            byte_if.BYTE_DATA  <= head_n;
            if (drop) begin
                OVERFLOW <= 1'b1;
                if (DROP_COUNT != 8'hFF) begin
                    DROP_COUNT <= DROP_COUNT + 8'd1;
                end
            end
        end
    end

    // FIFO storage, intentionally not reset
    always_ff @(posedge MCU_CLK_25_000) begin
        if (push_ok && !RESET_P) begin
            mem[wr_ptr] <= push_byte;
        end
    end
endmodule

// File: tb/tb_gps_sample_packer.sv
// Scoreboard bench for gps_sample_packer: stimulus queues expected bytes and
// expected status snapshots; a negedge monitor checks every popped byte and
// every status snapshot.
module tb_gps_sample_packer;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;

    logic          MCU_CLK_25_000 = 1'b0;
    logic          RESET_P        = 1'b1;
    logic          DATAREADY      = 1'b0;
    logic          GPS_I0         = 1'b0;
    logic          GPS_I1         = 1'b0;
    logic          GPS_Q0         = 1'b0;
    logic          GPS_Q1         = 1'b0;
    logic [AW:0]   FIFO_LEVEL;
    logic          OVERFLOW;
    logic [7:0]    DROP_COUNT;

    gps_sample_packer_if bus ();

    gps_sample_packer #(
        .FIFO_DEPTH(DEPTH),
        .ADDR_W    (AW)
    ) dut (
        .MCU_CLK_25_000(MCU_CLK_25_000),
        .RESET_P       (RESET_P),
        .DATAREADY     (DATAREADY),
        .GPS_I0        (GPS_I0),
        .GPS_I1        (GPS_I1),
        .GPS_Q0        (GPS_Q0),
        .GPS_Q1        (GPS_Q1),
        .byte_if       (bus.master),
        .FIFO_LEVEL    (FIFO_LEVEL),
        .OVERFLOW      (OVERFLOW),
        .DROP_COUNT    (DROP_COUNT)
    );

    always #20 MCU_CLK_25_000 = ~MCU_CLK_25_000;

    typedef struct {
        int          tag;
        logic [AW:0] level;
        logic        ovf;
        logic [7:0]  drop;
        logic        valid;
        logic [7:0]  data;
        bit          chk_empty;
    } stat_t;

    logic [7:0] exp_q [$];
    stat_t      stat_q [$];
    int         compared   = 0;
    int         mismatched = 0;

    // Monitor: byte scoreboard on handshakes, then pending status snapshots
    always @(negedge MCU_CLK_25_000) begin
        logic [7:0] e;
        stat_t      s;
        if (bus.BYTE_VALID && bus.BYTE_READY && !RESET_P) begin
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL byte_pop: got byte %02h, want no byte", bus.BYTE_DATA);
            end else begin
                e = exp_q.pop_front();
                if (bus.BYTE_DATA !== e) begin
                    mismatched++;
                    $display("FAIL byte_pop: got %02h, want %02h", bus.BYTE_DATA, e);
                end
            end
        end
        while (stat_q.size() != 0) begin
            s = stat_q.pop_front();
            compared++;
            if (FIFO_LEVEL !== s.level || OVERFLOW !== s.ovf || DROP_COUNT !== s.drop ||
                bus.BYTE_VALID !== s.valid || bus.BYTE_DATA !== s.data) begin
                mismatched++;
                $display("FAIL status#%0d: got level=%0d ovf=%b drop=%0d valid=%b data=%02h, want level=%0d ovf=%b drop=%0d valid=%b data=%02h",
                         s.tag, FIFO_LEVEL, OVERFLOW, DROP_COUNT, bus.BYTE_VALID, bus.BYTE_DATA,
                         s.level, s.ovf, s.drop, s.valid, s.data);
            end
            if (s.chk_empty) begin
                compared++;
                if (exp_q.size() != 0) begin
                    mismatched++;
                    $display("FAIL drained#%0d: got %0d bytes never popped, want 0", s.tag, exp_q.size());
                end
            end
        end
    end

    task automatic tick();
        @(posedge MCU_CLK_25_000);
        #1;
    endtask

    task automatic strobe(input logic [3:0] n);
        DATAREADY = 1'b1;
        {GPS_I1, GPS_I0, GPS_Q1, GPS_Q0} = n;
        tick();
        DATAREADY = 1'b0;
    endtask

    // Two strobes forming byte b; optionally raise BYTE_READY in the completing cycle
    task automatic send_byte(input logic [7:0] b, input bit stored, input bit rdy_last);
        strobe(b[7:4]);
        if (rdy_last) bus.BYTE_READY = 1'b1;
        strobe(b[3:0]);
        if (stored) exp_q.push_back(b);
    endtask

    task automatic post(input int tag, input int lvl, input logic ovf, input int drop,
                        input logic v, input logic [7:0] d, input bit ce);
        stat_t s;
        s.tag       = tag;
        s.level     = (AW+1)'(lvl);
        s.ovf       = ovf;
        s.drop      = 8'(drop);
        s.valid     = v;
        s.data      = d;
        s.chk_empty = ce;
        stat_q.push_back(s);
    endtask

    task automatic do_reset();
        bus.BYTE_READY = 1'b0;
        DATAREADY      = 1'b0;
        RESET_P        = 1'b1;
        tick();
        RESET_P        = 1'b0;
    endtask

    task automatic drain(input int n);
        bus.BYTE_READY = 1'b1;
        repeat (n) tick();
        bus.BYTE_READY = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        bus.BYTE_READY = 1'b0;
        tick();
        tick();
        RESET_P = 1'b0;

        // Idle after reset
        for (int i = 0; i < 20; i++) begin
            post(1, 0, 1'b0, 0, 1'b0, 8'h00, 1'b1);
            tick();
        end

        // Packing order: first sample goes to the high nibble
        strobe(4'hA);
        post(2, 0, 1'b0, 0, 1'b0, 8'h00, 1'b0);
        strobe(4'h5);
        exp_q.push_back(8'hA5);
        post(3, 1, 1'b0, 0, 1'b1, 8'hA5, 1'b0);
        drain(1);
        post(4, 0, 1'b0, 0, 1'b0, 8'h00, 1'b1);

        // Reset with bytes queued and a nibble held
        send_byte(8'h12, 1'b0, 1'b0);
        send_byte(8'h34, 1'b0, 1'b0);
        send_byte(8'h56, 1'b0, 1'b0);
        strobe(4'h7);
        post(5, 3, 1'b0, 0, 1'b1, 8'h12, 1'b0);
        do_reset();
        post(6, 0, 1'b0, 0, 1'b0, 8'h00, 1'b1);
        strobe(4'h8);
        post(7, 0, 1'b0, 0, 1'b0, 8'h00, 1'b0);
        strobe(4'h9);
        exp_q.push_back(8'h89);
        post(8, 1, 1'b0, 0, 1'b1, 8'h89, 1'b0);
        drain(1);
        post(9, 0, 1'b0, 0, 1'b0, 8'h00, 1'b1);

        // Streaming with the consumer always ready, one strobe every 6 cycles
        bus.BYTE_READY = 1'b1;
        for (int k = 0; k < 16; k++) begin
            strobe(4'(k));
            if (k % 2 == 1) begin
                b = 8'((k - 1) * 16 + k);
                exp_q.push_back(b);
                post(10, 1, 1'b0, 0, 1'b1, b, 1'b0);
            end else begin
                post(11, 0, 1'b0, 0, 1'b0, 8'h00, 1'b0);
            end
            repeat (5) tick();
            post(12, 0, 1'b0, 0, 1'b0, 8'h00, 1'b0);
        end
        bus.BYTE_READY = 1'b0;
        post(13, 0, 1'b0, 0, 1'b0, 8'h00, 1'b1);

        // Fill to 16, then one more byte is dropped
        for (int p = 0; p < 17; p++) begin
            b = 8'(8'h11 * p);
            send_byte(b, (p < 16), 1'b0);
            if (p == 15) post(15, 16, 1'b0, 0, 1'b1, 8'h00, 1'b0);
        end
        post(14, 16, 1'b1, 1, 1'b1, 8'h00, 1'b0);
        drain(16);
        post(16, 0, 1'b1, 1, 1'b0, 8'h00, 1'b1);

        // Full FIFO with pop in the cycle a byte completes: push still dropped
        do_reset();
        post(17, 0, 1'b0, 0, 1'b0, 8'h00, 1'b1);
        for (int p = 0; p < 16; p++) send_byte(8'(p * 16 + 5), 1'b1, 1'b0);
        send_byte(8'h77, 1'b0, 1'b1);
        bus.BYTE_READY = 1'b0;
        post(18, 15, 1'b1, 1, 1'b1, 8'h15, 1'b0);
        drain(15);
        post(19, 0, 1'b1, 1, 1'b0, 8'h00, 1'b1);

        // Level 5 with simultaneous push and pop, pointers straddling the wrap
        for (int p = 0; p < 14; p++) send_byte(8'(8'h40 + p), 1'b1, 1'b0);
        drain(14);
        post(20, 0, 1'b1, 1, 1'b0, 8'h00, 1'b1);
        for (int p = 0; p < 5; p++) send_byte(8'(8'hA0 + p), 1'b1, 1'b0);
        post(21, 5, 1'b1, 1, 1'b1, 8'hA0, 1'b0);
        send_byte(8'hA5, 1'b1, 1'b1);
        bus.BYTE_READY = 1'b0;
        post(22, 5, 1'b1, 1, 1'b1, 8'hA1, 1'b0);
        drain(5);
        post(23, 0, 1'b1, 1, 1'b0, 8'h00, 1'b1);

        // Drop counter saturation; stored contents must be untouched
        do_reset();
        for (int p = 0; p < 16; p++) send_byte(8'(p * 7 + 1), 1'b1, 1'b0);
        for (int d = 0; d < 300; d++) begin
            send_byte(8'(d), 1'b0, 1'b0);
            if (d == 253) post(24, 16, 1'b1, 254, 1'b1, 8'h01, 1'b0);
            if (d == 254) post(25, 16, 1'b1, 255, 1'b1, 8'h01, 1'b0);
        end
        post(26, 16, 1'b1, 255, 1'b1, 8'h01, 1'b0);
        drain(16);
        post(27, 0, 1'b1, 255, 1'b0, 8'h00, 1'b1);

        tick();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
